// File: rtl/counter_chk_pkg.sv
// Shared types and the next-value function of the up3/dn2 counter.
// The counter's formal properties use this package as well.
package counter_chk_pkg;

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        CHECK   = 2'd1,
        FAIL    = 2'd2
    } chk_state_t;

    localparam int ERR_CNT_W = 8;
    localparam int STEP_W    = 32;

    typedef logic [STEP_W-1:0] step_t;

    // Works on a wide value; callers truncate to their width to get modulo-2^WIDTH wrap.
    function automatic step_t cnt_step(input step_t cur, input logic up3, input logic dn2);
        step_t nxt;
        case ({up3, dn2})
            2'b10:   nxt = cur + step_t'(3);
            2'b01:   nxt = cur - step_t'(2);
            2'b11:   nxt = cur + step_t'(1);
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/counter_model.sv
// Registered golden model of the up3/dn2 counter; usable standalone.
module counter_model
    import counter_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up3,
    input  logic             dn2,
    output logic [WIDTH-1:0] model
);

    always_ff @(posedge clk) begin
        if (rst) begin
            model <= '0;
        end else begin
            model <= WIDTH'(cnt_step(STEP_W'(model), up3, dn2));
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Self-checking monitor for the up3/dn2 counter: compares cnt against a
// reference model every cycle and records diagnostics for the first mismatch.
//
// state   | meaning
// UNARMED | no reset seen yet; nothing is compared
// CHECK   | comparing every cycle, no mismatch so far
// FAIL    | at least one mismatch; first-failure captures frozen
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CYC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up3,
    input  logic                 dn2,
    input  logic [WIDTH-1:0]     cnt,
    output logic                 armed,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CYC_W-1:0]     cyc,
    output logic [CYC_W-1:0]     first_cyc,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_got
);

    // Power-up value: the checker must read as unarmed before any reset arrives.
    chk_state_t       state = UNARMED;
    chk_state_t       next_state;
    logic [WIDTH-1:0] model;
    logic             mismatch;

    counter_model #(.WIDTH(WIDTH)) u_model (
        .clk   (clk),
        .rst   (rst),
        .up3   (up3),
        .dn2   (dn2),
        .model (model)
    );

    // Case-inequality so X/Z on cnt counts as a mismatch in simulation.
    assign mismatch = (state != UNARMED) && !rst && (cnt !== model);

    always_ff @(posedge clk) begin
        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (rst) begin
            next_state = CHECK;
        end else begin
            case (state)
                CHECK:   if (mismatch) next_state = FAIL;
                FAIL:    next_state = FAIL;
                default: next_state = UNARMED;
            endcase
        end
    end

    always_comb begin
        armed = 1'b0;
        err   = 1'b0;
        case (state)
            CHECK: armed = 1'b1;
            FAIL: begin
                armed = 1'b1;
                err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            err_cnt   <= '0;
            first_cyc <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            cyc <= cyc + CYC_W'(1);
            if (mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            if (mismatch && (state == CHECK)) begin
                first_cyc <= cyc;
                first_exp <= model;
                first_got <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: vector table plus hand-written multi-cycle sequences.
module tb_counter_checker;
    import counter_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        up3 = 1'b0;
    logic        dn2 = 1'b0;
    logic [3:0]  cnt = 4'd0;
    logic        armed;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] cyc;
    logic [15:0] first_cyc;
    logic [3:0]  first_exp;
    logic [3:0]  first_got;

    int checks = 0;
    int errors = 0;

    counter_checker #(.WIDTH(4), .CYC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .up3       (up3),
        .dn2       (dn2),
        .cnt       (cnt),
        .armed     (armed),
        .err       (err),
        .err_cnt   (err_cnt),
        .cyc       (cyc),
        .first_cyc (first_cyc),
        .first_exp (first_exp),
        .first_got (first_got)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        up3;
        logic        dn2;
        logic [3:0]  cnt;
        logic        armed;
        logic        err;
        logic [7:0]  err_cnt;
        logic [15:0] cyc;
        logic [15:0] fcyc;
        logic [3:0]  fexp;
        logic [3:0]  fgot;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input int r, input int u, input int d, input int c,
                                input int a, input int e, input int ec, input int cy,
                                input int fc, input int fe, input int fg);
        vec_t v;
        v.rst     = 1'(r);
        v.up3     = 1'(u);
        v.dn2     = 1'(d);
        v.cnt     = 4'(c);
        v.armed   = 1'(a);
        v.err     = 1'(e);
        v.err_cnt = 8'(ec);
        v.cyc     = 16'(cy);
        v.fcyc    = 16'(fc);
        v.fexp    = 4'(fe);
        v.fgot    = 4'(fg);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input logic r, input logic u, input logic d, input logic [3:0] c);
        @(negedge clk);
        rst = r;
        up3 = u;
        dn2 = d;
        cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".armed"},     32'(armed),     32'(v.armed));
        chk({tag, ".err"},       32'(err),       32'(v.err));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(v.err_cnt));
        chk({tag, ".cyc"},       32'(cyc),       32'(v.cyc));
        chk({tag, ".first_cyc"}, 32'(first_cyc), 32'(v.fcyc));
        chk({tag, ".first_exp"}, 32'(first_exp), 32'(v.fexp));
        chk({tag, ".first_got"}, 32'(first_got), 32'(v.fgot));
    endtask

    initial begin
        //               rst up dn cnt  arm err ec  cyc fcyc fexp fgot
        vecs[0]  = mk(1, 0, 0,  7,   1, 0, 0,  0,  0, 0, 0);  // first reset, cnt ignored
        vecs[1]  = mk(0, 1, 0,  0,   1, 0, 0,  1,  0, 0, 0);
        vecs[2]  = mk(0, 0, 1,  3,   1, 0, 0,  2,  0, 0, 0);
        vecs[3]  = mk(0, 1, 1,  1,   1, 0, 0,  3,  0, 0, 0);
        vecs[4]  = mk(0, 0, 0,  2,   1, 0, 0,  4,  0, 0, 0);
        vecs[5]  = mk(0, 0, 0,  2,   1, 0, 0,  5,  0, 0, 0);
        vecs[6]  = mk(0, 1, 0,  2,   1, 0, 0,  6,  0, 0, 0);
        vecs[7]  = mk(0, 1, 0,  5,   1, 0, 0,  7,  0, 0, 0);
        vecs[8]  = mk(0, 1, 0,  8,   1, 0, 0,  8,  0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 11,   1, 0, 0,  9,  0, 0, 0);
        vecs[10] = mk(0, 1, 0, 14,   1, 0, 0, 10,  0, 0, 0);  // 14+3 wraps to 1
        vecs[11] = mk(0, 0, 1,  1,   1, 0, 0, 11,  0, 0, 0);  // 1-2 wraps to 15
        vecs[12] = mk(0, 0, 1, 15,   1, 0, 0, 12,  0, 0, 0);
        vecs[13] = mk(0, 0, 0, 13,   1, 0, 0, 13,  0, 0, 0);
        vecs[14] = mk(1, 0, 0,  6,   1, 0, 0,  0,  0, 0, 0);  // mismatch on reset edge ignored
        vecs[15] = mk(0, 0, 0,  0,   1, 0, 0,  1,  0, 0, 0);
        vecs[16] = mk(0, 1, 0,  0,   1, 0, 0,  2,  0, 0, 0);
        vecs[17] = mk(0, 0, 0,  5,   1, 1, 1,  3,  2, 3, 5);  // injected fault at cyc=2
        vecs[18] = mk(0, 0, 1,  3,   1, 1, 1,  4,  2, 3, 5);
        vecs[19] = mk(0, 0, 0,  9,   1, 1, 2,  5,  2, 3, 5);  // later mismatch keeps first_*
        vecs[20] = mk(0, 0, 0,  1,   1, 1, 2,  6,  2, 3, 5);

        // Pre-reset: garbage cnt from power-up, checker stays quiet.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
            chk($sformatf("prerst%0d.armed", i), 32'(armed), 32'd0);
            chk($sformatf("prerst%0d.err", i),   32'(err),   32'd0);
        end

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].up3, vecs[i].dn2, vecs[i].cnt);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Model holds at 1; five more wrong cycles bring err_cnt to 7.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("prefail.err_cnt", 32'(err_cnt), 32'd7);
        chk("prefail.err",     32'(err),     32'd1);

        // Reset mid-failure with a wrong cnt on the reset edge.
        step(1'b1, 1'b0, 1'b0, 4'd9);
        chk_all("midrst", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk_all("resume_ok", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 4'd1);
        chk_all("resume_bad", mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 1));

        // Saturation: 300 more wrong cycles, err_cnt pins at 255 while cyc keeps going.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd1);
            if (i == 253) chk("sat.err_cnt_255_reached", 32'(err_cnt), 32'd255);
        end
        chk_all("sat", mk(0, 0, 0, 0, 1, 1, 255, 302, 1, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
# counter_checker

Synchronous self-checking monitor for the up3/dn2 counter. It sits beside the counter in the simulation/formal bench and watches the same `rst`, `up3` and `dn2` nets plus the counter's `cnt` output. It holds a cycle-accurate reference model of the counter and flags any mismatch. It also captures diagnostics for the first failure, so benches can end on a single sticky flag instead of open-coded assertions.

## Interface
Parameters:
- `WIDTH`, 4: counter width; must match the instance being checked.
- `CYC_W`, 16: width of the cycle counter and the first-failure timestamp.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset. The same net resets the counter under check, so the checker both resets itself and models that reset.
- `up3` input 1: observed "add 3" request.
- `dn2` input 1: observed "subtract 2" request.
- `cnt` input WIDTH: observed counter output.
- `armed` output 1: high once a reset has been seen; checks are active.
- `err` output 1: sticky mismatch flag.
- `err_cnt` output 8: number of mismatching cycles, saturating at 255.
- `cyc` output CYC_W: edges since the last reset; wraps.
- `first_cyc` output CYC_W: value of `cyc` at the first mismatch.
- `first_exp` output WIDTH: model value at the first mismatch.
- `first_got` output WIDTH: `cnt` value at the first mismatch.

## Operation
- **Reference model register `model`.** Applied to each sampled {rst, up3, dn2}:
  - `rst=1` → 0.
  - `up3` only → model+3.
  - `dn2` only → model−2.
  - both → model+1.
  - neither → hold.
  - All arithmetic is modulo 2^WIDTH; wrap is silent and is not an error.
- **FSM `state`:**
  - UNARMED (power-up) → CHECK on any edge with `rst=1`.
  - CHECK → FAIL on the first mismatch.
  - FAIL stays sticky until `rst`.
  - `rst` in any state → CHECK (re-armed, diagnostics cleared).
- **Compare rule.** On each edge with `state≠UNARMED` and `rst=0`, compare the pre-edge `cnt` with the pre-edge `model`. There is no comparison on `rst=1` edges or while UNARMED.
- **On a mismatch:**
  - `err_cnt` increments (saturating).
  - If the mismatch occurs in CHECK, capture `first_cyc`, `first_exp` and `first_got`; these captures hold while in FAIL.
- **On a `rst=1` edge:**
  - `model`, `cyc`, `err_cnt`, `first_*` ← 0.
  - `err` ← 0.
  - `state` ← CHECK.
- **Simultaneous events:** a mismatch on the same edge as `rst=1` is ignored, because reset wins.
- **Unknowns:** X/Z on `cnt` counts as a mismatch in simulation (use case-inequality).

## Timing
- **Reset values of outputs:**
  - Power-up before any reset: `armed=0`, `err=0`; all other outputs 0 only after the first reset (unspecified before it).
  - After a `rst` edge: `armed=1`, `err=0`, counters and captures 0.
- **Latency:** the counter's `cnt` is registered, so `cnt` in cycle n reflects inputs sampled at edge n−1. The model matches this 1-cycle latency by construction.
- **Flag timing:** `err` rises on the edge that detects the mismatch and is visible one cycle after the offending `cnt` value.
- **Cycle count:** `cyc` increments on every non-reset edge and wraps at 2^CYC_W without affecting checking.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs.

## Structure
- **Package `counter_chk_pkg`:**
  - `chk_state_t` enum {UNARMED, CHECK, FAIL}.
  - `ERR_CNT_W = 8`.
  - Function `cnt_step(cur, up3, dn2)` returning the next model value.
  - The package is shared by the counter's formal properties.
- **Sub-module `counter_model`:** the registered reference counter (clk, rst, up3, dn2 → model). It is reusable as a golden model elsewhere; the checker instantiates it once.
- **Size:** target 150–250 lines of RTL in total.

## Test plan
Use WIDTH=4.

1. **Canonical sequence.** Edges: rst; up3; dn2; up3+dn2; idle. Expected model/cnt values 0, 3, 1, 2, 2. With a correct DUT: `armed=1`, `err=0`, `err_cnt=0`.
2. **Wrap-around.** From model 14, apply up3 → expect 1. Then dn2 ×1 → 15. Then dn2 → 13. No error.
3. **Injected fault.** Force `cnt=5` on the cycle where 3 is expected, at `cyc=2`. Expect `err=1` on the next edge, `first_cyc=2`, `first_exp=3`, `first_got=5`, `err_cnt=1`. A later mismatch increments `err_cnt` but leaves the `first_*` values unchanged.
4. **Pre-reset.** Drive garbage `cnt` for 5 cycles with `rst=0` from power-up. Expect `armed=0` and `err=0` throughout.
5. **Reset mid-failure.** In FAIL with `err_cnt=7`, assert `rst` for 1 cycle. Expect `err=0`, `err_cnt=0`, `first_*=0`, `cyc=0`, and checking resumes against model 0.
6. **Saturation.** Hold `cnt` wrong for 300 cycles. Expect `err_cnt` to stop at 255, and `cyc` to continue counting.
